// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: GRB pixels in on a valid/ready stream,
// pulse-width-coded bits out MSB-first, latch low time after each frame.
module ws2812_tx #(
   parameter int CLK_FREQ = 12_000_000,
   parameter int NUM_LEDS = 8,
   parameter int T0H_NS   = 400,
   parameter int T1H_NS   = 800,
   parameter int TBIT_NS  = 1250,
   parameter int RESET_US = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] pixel_data,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   output logic        led_data,
   output logic        busy,
   output logic        frame_done,
   output logic [9:0]  led_idx
);

   localparam longint KHZ = longint'(CLK_FREQ) / 1000;

   localparam int T0H_CYC   = int'((KHZ * T0H_NS + 500_000) / 1_000_000);
   localparam int T1H_CYC   = int'((KHZ * T1H_NS + 500_000) / 1_000_000);
   localparam int TBIT_CYC  = int'((KHZ * TBIT_NS + 500_000) / 1_000_000);
   localparam int RESET_CYC = (CLK_FREQ / 1_000_000) * RESET_US;

   localparam int MAXC = (TBIT_CYC > RESET_CYC) ? TBIT_CYC : RESET_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] C_T0H_LAST  = CW'(T0H_CYC - 1);
   localparam logic [CW-1:0] C_T1H_LAST  = CW'(T1H_CYC - 1);
   localparam logic [CW-1:0] C_TBIT_LAST = CW'(TBIT_CYC - 1);
   localparam logic [CW-1:0] C_RST_LAST  = CW'(RESET_CYC - 1);
   localparam logic [CW-1:0] C_RST_PRE   =
      CW'((RESET_CYC >= 2) ? RESET_CYC - 2 : 0);
   localparam logic [9:0]    IDX_LAST    = 10'(NUM_LEDS - 1);

   if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC
         && RESET_CYC >= 1)) begin : g_bad_timing
      $error("ws2812_tx: derived bit/latch timing is not realisable");
   end

   if (NUM_LEDS < 1 || NUM_LEDS > 1023) begin : g_bad_leds
      $error("ws2812_tx: NUM_LEDS out of range 1..1023");
   end

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW,
      LATCH
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [23:0]   r_shift;
   logic [4:0]    r_bit;
   logic [9:0]    r_idx;
   logic          r_led;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;

   logic [CW-1:0] w_hi_last;

   assign w_hi_last = r_shift[23] ? C_T1H_LAST : C_T0H_LAST;

   // r_cnt counts cycles inside the current bit (HIGH then LOW)
   // or inside the latch period.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
         r_idx   <= '0;
         r_led   <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (pixel_valid && r_ready) begin
                  r_shift <= pixel_data;
                  r_bit   <= 5'd23;
                  r_cnt   <= '0;
                  r_led   <= 1'b1;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= HIGH;
               end
            end
            HIGH: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == w_hi_last) begin
                  r_led   <= 1'b0;
                  r_state <= LOW;
               end
            end
            LOW: begin
               if (r_cnt == C_TBIT_LAST) begin
                  r_cnt <= '0;
                  if (r_bit != 5'd0) begin
                     r_bit   <= r_bit - 5'd1;
                     r_shift <= {r_shift[22:0], 1'b0};
                     r_led   <= 1'b1;
                     r_state <= HIGH;
                  end else if (r_idx == IDX_LAST) begin
                     r_idx   <= '0;
                     r_done  <= (RESET_CYC == 1);
                     r_state <= LATCH;
                  end else begin
                     r_idx   <= r_idx + 10'd1;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            LATCH: begin
               if (r_cnt == C_RST_LAST) begin
                  r_cnt   <= '0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  // frame_done lands on the final latch cycle
                  r_cnt  <= r_cnt + 1'b1;
                  r_done <= (r_cnt == C_RST_PRE);
               end
            end
         endcase
      end
   end

   assign pixel_ready = r_ready;
   assign led_data    = r_led;
   assign busy        = r_busy;
   assign frame_done  = r_done;
   assign led_idx     = r_idx;

endmodule
